gpio_mpe_ctrl: RTL and testbench
================================

Name: gpio_mpe_ctrl

Overview:
- Parametrised multi-PE GPIO controller. Successor to the fixed 16-pin / 3-PE GPIO peripheral.
- Adds per-pin input synchronisation and debounce, rise/fall/both-edge interrupt select, W1C status, atomic set/clear/toggle output registers, and programmable interrupt routing to any PE subset.
- Sits on the peripheral bus, one port slice per PE; drives the pad-level GPIO pins.

Parameters:
- GPIO_W, 16, pin count (1..32).
- NUM_PE, 3, number of PE bus slices (1..8).
- DB_CNT_W, 8, debounce counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_gpio  in  GPIO_W  pad input
- o_gpio  out  GPIO_W  pad output value
- o_gpio_en  out  GPIO_W  output enable, 1 = drive
- i_addr_32b  in  NUM_PE*32  per-PE byte address; word offset = [5:2]
- i_wren  in  NUM_PE  per-PE write strobe
- i_rden  in  NUM_PE  per-PE read strobe
- i_din_32b  in  NUM_PE*32  per-PE write data
- o_dout_32b  out  NUM_PE*32  per-PE read data
- o_dout_32b_valid  out  NUM_PE  read/write ack
- o_interrupt  out  NUM_PE  per-PE level interrupt

Behaviour:
- Reset: every register, output and o_dout/valid/interrupt = 0; sync and filter flops = 0.
- Register map (word offset), data in bits [GPIO_W-1:0], upper bits read 0:
  - 0 EN: bit0 only.
  - 1 IRQ_EN: per-pin interrupt mask.
  - 2 RISE: per-pin rising-edge enable.
  - 3 FALL: per-pin falling-edge enable; RISE and FALL both set = both edges.
  - 4 STATUS: W1C.
  - 5 DIR: 1 = output.
  - 6 IN: read-only, debounced value.
  - 7 OUT: read/write.
  - 8 OUT_SET / 9 OUT_CLR / 10 OUT_TGL: write-only, read 0.
  - 11 DB_LIMIT: [DB_CNT_W-1:0].
  - 12 IRQ_ROUTE: [NUM_PE-1:0].
  - 13–15: reserved, read 0, writes ignored.
- Bus timing:
  - o_dout_32b_valid[p] registered from i_wren[p] | i_rden[p]; 1-cycle latency.
  - o_dout_32b[p] is updated every cycle from its address, and reflects register state before any same-cycle write.
- Write arbitration: if several PEs write in the same cycle, the lowest-index PE's write is applied. All writers still receive valid; losing writes are silently dropped.
- Input path per pin:
  - 2-flop synchroniser, then debounce filter.
  - Counter increments while sync != filtered and clears when they are equal.
  - When counter == DB_LIMIT, filtered <= sync and counter clears.
  - DB_LIMIT = 0 means filtered follows sync with 1 cycle of delay.
  - Counter saturates and never wraps.
- Edge detection uses filtered versus its previous value:
  - STATUS[i] sets on a rising edge with RISE[i], or a falling edge with FALL[i].
  - W1C clears STATUS bits; a same-cycle set beats a clear.
  - EN = 0 holds STATUS at 0 and suppresses detection. The filter keeps tracking, so enabling EN never produces a spurious edge.
- Interrupt: o_interrupt[p] = EN & |(STATUS & IRQ_EN) & IRQ_ROUTE[p], registered (1 cycle after STATUS).
- OUT update priority within one cycle: OUT write > SET > CLR > TGL (only one applies, since there is a single winning writer). o_gpio = OUT, o_gpio_en = DIR, both regardless of EN.
- Pins with DIR = 1 still pass through the input path; the IN register shows the pad value.
- Reset mid-debounce: counters and filtered flops clear asynchronously; no edge is reported after release until a real transition.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined: debounce counters and the DB_LIMIT register exist as described.
- Undefined: filtered = synchroniser output directly, with no extra cycle. DB_LIMIT reads 0 and writes are ignored. No counter logic is generated.

Decomposition:
- Package gpio_mpe_pkg:
  - register offset localparams (REG_EN … REG_IRQ_ROUTE);
  - ADDR_LSB = 2, ADDR_W = 4;
  - a function for packing read data to 32 bits.
- Sub-module gpio_in_filter: a single pin's synchroniser, debounce counter, filtered flop and previous-value flop. Ports: clk, rst_n, raw, db_limit; outputs filt, rise, fall. Instantiated GPIO_W times by generate.

Test Plan:
- Reset with i_gpio = 16'hFFFF, EN = 0, then write EN = 1 -> STATUS stays 0 and o_interrupt = 0.
- DB_LIMIT = 4, RISE[3] = 1, IRQ_EN[3] = 1, IRQ_ROUTE = 3'b010, EN = 1; pulse pin3 high for 3 cycles -> no status. Hold high for 10 cycles -> STATUS = 16'h0008 and o_interrupt = 3'b010. Write 16'h0008 to STATUS -> o_interrupt returns to 0 two cycles later.
- RISE[0] = FALL[0] = 1, DB_LIMIT = 0; toggle pin0 0->1->0 -> STATUS[0] set on each edge. A W1C issued in the same cycle as a new edge leaves STATUS[0] = 1.
- OUT = 16'h00F0; SET 16'h000F; CLR 16'h0030; TGL 16'hFF00 -> o_gpio = 16'hFFCF. DIR = 16'hFFFF -> o_gpio_en = 16'hFFFF.
- PE0 writes OUT = 16'h1111 and PE2 writes OUT = 16'h2222 in the same cycle -> OUT = 16'h1111, o_dout_32b_valid = 3'b101 next cycle.
- GPIO_DEBOUNCE_EN undefined: pin edge reaches STATUS 3 cycles after pad change; DB_LIMIT write 8'h10 reads back 0.

Source files
------------

// File: rtl/gpio_mpe_pkg.sv
// Shared constants and helpers for the multi-PE GPIO controller.
package gpio_mpe_pkg;

   localparam int unsigned ADDR_LSB = 2;
   localparam int unsigned ADDR_W   = 4;

   localparam logic [ADDR_W-1:0] REG_EN        = 4'd0;
   localparam logic [ADDR_W-1:0] REG_IRQ_EN    = 4'd1;
   localparam logic [ADDR_W-1:0] REG_RISE      = 4'd2;
   localparam logic [ADDR_W-1:0] REG_FALL      = 4'd3;
   localparam logic [ADDR_W-1:0] REG_STATUS    = 4'd4;
   localparam logic [ADDR_W-1:0] REG_DIR       = 4'd5;
   localparam logic [ADDR_W-1:0] REG_IN        = 4'd6;
   localparam logic [ADDR_W-1:0] REG_OUT       = 4'd7;
   localparam logic [ADDR_W-1:0] REG_OUT_SET   = 4'd8;
   localparam logic [ADDR_W-1:0] REG_OUT_CLR   = 4'd9;
   localparam logic [ADDR_W-1:0] REG_OUT_TGL   = 4'd10;
   localparam logic [ADDR_W-1:0] REG_DB_LIMIT  = 4'd11;
   localparam logic [ADDR_W-1:0] REG_IRQ_ROUTE = 4'd12;

   // Zero-extended register value to a 32-bit read word, keeping only 'width' LSBs.
   function automatic logic [31:0] rd_pack(input logic [31:0] val, input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return val & mask;
   endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One pin's input path: 2-flop synchroniser, optional debounce, edge detect.
// Debounce counter exists only when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter
   import gpio_mpe_pkg::*;
#(
   parameter int unsigned DB_CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                raw,
   input  logic [DB_CNT_W-1:0] db_limit,
   output logic                filt,
   output logic                rise,
   output logic                fall
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   logic                filt_q;
   logic [DB_CNT_W-1:0] cnt_q;

   // Accept the synchronised value only once it has differed for db_limit cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else if (sync2_q == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == db_limit) begin
         filt_q <= sync2_q;
         cnt_q  <= '0;
      end else if (cnt_q != '1) begin
         cnt_q <= cnt_q + DB_CNT_W'(1);
      end
   end

   assign filt = filt_q;
`else
   logic unused_db_limit;
   assign unused_db_limit = ^db_limit;
   assign filt            = sync2_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= filt;
   end

   assign rise = filt & ~prev_q;
   assign fall = ~filt & prev_q;

endmodule

// File: rtl/gpio_mpe_ctrl.sv
// Multi-PE GPIO controller: per-PE bus slices, W1C edge status, atomic output ops.
// Define GPIO_DEBOUNCE_EN to build the per-pin debounce counters and DB_LIMIT register.
module gpio_mpe_ctrl
   import gpio_mpe_pkg::*;
#(
   parameter int unsigned GPIO_W   = 16,
   parameter int unsigned NUM_PE   = 3,
   parameter int unsigned DB_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [GPIO_W-1:0]    i_gpio,
   output logic [GPIO_W-1:0]    o_gpio,
   output logic [GPIO_W-1:0]    o_gpio_en,
   input  logic [NUM_PE*32-1:0] i_addr_32b,
   input  logic [NUM_PE-1:0]    i_wren,
   input  logic [NUM_PE-1:0]    i_rden,
   input  logic [NUM_PE*32-1:0] i_din_32b,
   output logic [NUM_PE*32-1:0] o_dout_32b,
   output logic [NUM_PE-1:0]    o_dout_32b_valid,
   output logic [NUM_PE-1:0]    o_interrupt
);

   logic                en_q,      en_n;
   logic [GPIO_W-1:0]   irq_en_q,  irq_en_n;
   logic [GPIO_W-1:0]   rise_en_q, rise_en_n;
   logic [GPIO_W-1:0]   fall_en_q, fall_en_n;
   logic [GPIO_W-1:0]   status_q,  status_n;
   logic [GPIO_W-1:0]   dir_q,     dir_n;
   logic [GPIO_W-1:0]   out_q,     out_n;
   logic [NUM_PE-1:0]   route_q,   route_n;
   logic [DB_CNT_W-1:0] db_limit_c;

   logic [GPIO_W-1:0]   filt;
   logic [GPIO_W-1:0]   rise;
   logic [GPIO_W-1:0]   fall;
   logic [GPIO_W-1:0]   edge_set;
   logic [GPIO_W-1:0]   w1c;

   logic                wr_hit;
   logic [ADDR_W-1:0]   wr_addr;
   logic [31:0]         wr_data;

   logic                unused_bus;
   assign unused_bus = ^{i_addr_32b, wr_data};

   genvar gi;
   generate
      for (gi = 0; gi < GPIO_W; gi++) begin : g_pin
         gpio_in_filter #(.DB_CNT_W(DB_CNT_W)) u_filter (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .raw      (i_gpio[gi]),
            .db_limit (db_limit_c),
            .filt     (filt[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi])
         );
      end
   endgenerate

   // Lowest-index writing PE wins; scanning downward lets it overwrite the others.
   always_comb begin
      wr_hit  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      for (int p = int'(NUM_PE) - 1; p >= 0; p--) begin
         if (i_wren[p]) begin
            wr_hit  = 1'b1;
            wr_addr = i_addr_32b[p*32 + int'(ADDR_LSB) +: ADDR_W];
            wr_data = i_din_32b[p*32 +: 32];
         end
      end
   end

   assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);

`ifdef GPIO_DEBOUNCE_EN
   logic [DB_CNT_W-1:0] db_limit_q, db_limit_n;
   assign db_limit_c = db_limit_q;
`else
   assign db_limit_c = '0;
`endif

   // Register file next-state; set beats W1C on the same cycle.
   always_comb begin
      en_n      = en_q;
      irq_en_n  = irq_en_q;
      rise_en_n = rise_en_q;
      fall_en_n = fall_en_q;
      dir_n     = dir_q;
      out_n     = out_q;
      route_n   = route_q;
      w1c       = '0;
`ifdef GPIO_DEBOUNCE_EN
      db_limit_n = db_limit_q;
`endif
      if (wr_hit) begin
         case (wr_addr)
            REG_EN:        en_n      = wr_data[0];
            REG_IRQ_EN:    irq_en_n  = wr_data[GPIO_W-1:0];
            REG_RISE:      rise_en_n = wr_data[GPIO_W-1:0];
            REG_FALL:      fall_en_n = wr_data[GPIO_W-1:0];
            REG_STATUS:    w1c       = wr_data[GPIO_W-1:0];
            REG_DIR:       dir_n     = wr_data[GPIO_W-1:0];
            REG_OUT:       out_n     = wr_data[GPIO_W-1:0];
            REG_OUT_SET:   out_n     = out_q | wr_data[GPIO_W-1:0];
            REG_OUT_CLR:   out_n     = out_q & ~wr_data[GPIO_W-1:0];
            REG_OUT_TGL:   out_n     = out_q ^ wr_data[GPIO_W-1:0];
            REG_DB_LIMIT: begin
`ifdef GPIO_DEBOUNCE_EN
               db_limit_n = wr_data[DB_CNT_W-1:0];
`endif
            end
            REG_IRQ_ROUTE: route_n   = wr_data[NUM_PE-1:0];
            default: ;
         endcase
      end
      status_n = en_q ? ((status_q & ~w1c) | edge_set) : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en_q      <= 1'b0;
         irq_en_q  <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         dir_q     <= '0;
         out_q     <= '0;
         route_q   <= '0;
`ifdef GPIO_DEBOUNCE_EN
         db_limit_q <= '0;
`endif
      end else begin
         en_q      <= en_n;
         irq_en_q  <= irq_en_n;
         rise_en_q <= rise_en_n;
         fall_en_q <= fall_en_n;
         status_q  <= status_n;
         dir_q     <= dir_n;
         out_q     <= out_n;
         route_q   <= route_n;
`ifdef GPIO_DEBOUNCE_EN
         db_limit_q <= db_limit_n;
`endif
      end
   end

   function automatic logic [31:0] rd_mux(input logic [ADDR_W-1:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         REG_EN:        v = rd_pack(32'(en_q), 1);
         REG_IRQ_EN:    v = rd_pack(32'(irq_en_q), GPIO_W);
         REG_RISE:      v = rd_pack(32'(rise_en_q), GPIO_W);
         REG_FALL:      v = rd_pack(32'(fall_en_q), GPIO_W);
         REG_STATUS:    v = rd_pack(32'(status_q), GPIO_W);
         REG_DIR:       v = rd_pack(32'(dir_q), GPIO_W);
         REG_IN:        v = rd_pack(32'(filt), GPIO_W);
         REG_OUT:       v = rd_pack(32'(out_q), GPIO_W);
`ifdef GPIO_DEBOUNCE_EN
         REG_DB_LIMIT:  v = rd_pack(32'(db_limit_q), DB_CNT_W);
`endif
         REG_IRQ_ROUTE: v = rd_pack(32'(route_q), NUM_PE);
         default:       v = '0;
      endcase
      return v;
   endfunction

   // Read data tracks the address every cycle and shows pre-write state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dout_32b       <= '0;
         o_dout_32b_valid <= '0;
         o_interrupt      <= '0;
      end else begin
         o_dout_32b_valid <= i_wren | i_rden;
         for (int p = 0; p < int'(NUM_PE); p++) begin
            o_dout_32b[p*32 +: 32] <= rd_mux(i_addr_32b[p*32 + int'(ADDR_LSB) +: ADDR_W]);
         end
         o_interrupt <= (en_q && (|(status_q & irq_en_q))) ? route_q : '0;
      end
   end

   assign o_gpio    = out_q;
   assign o_gpio_en = dir_q;

endmodule

// File: tb/tb_gpio_mpe_ctrl.sv
// Scoreboard bench for gpio_mpe_ctrl (default 16 pins, 3 PEs).
module tb_gpio_mpe_ctrl;

   localparam logic [3:0] R_EN = 4'd0, R_IRQ_EN = 4'd1, R_RISE = 4'd2, R_FALL = 4'd3;
   localparam logic [3:0] R_STATUS = 4'd4, R_DIR = 4'd5, R_IN = 4'd6, R_OUT = 4'd7;
   localparam logic [3:0] R_SET = 4'd8, R_CLR = 4'd9, R_TGL = 4'd10, R_DB = 4'd11;
   localparam logic [3:0] R_ROUTE = 4'd12, R_RSVD = 4'd13;
`ifdef GPIO_DEBOUNCE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] gpio, o_gpio, o_gpio_en;
   logic [95:0] addr, din, dout;
   logic [2:0]  wren, rden, valid, irq;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          pe;
      bit          chk;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   gpio_mpe_ctrl dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_gpio           (gpio),
      .o_gpio           (o_gpio),
      .o_gpio_en        (o_gpio_en),
      .i_addr_32b       (addr),
      .i_wren           (wren),
      .i_rden           (rden),
      .i_din_32b        (din),
      .o_dout_32b       (dout),
      .o_dout_32b_valid (valid),
      .o_interrupt      (irq)
   );

   // Scoreboard: every ack pops the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int p = 0; p < 3; p++) begin
            if (valid[p]) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL ack_unexpected pe%0d", p);
               end else begin
                  e = exp_q.pop_front();
                  if (e.pe != p || (e.chk && dout[p*32 +: 32] !== e.data)) begin
                     n_err++;
                     $display("FAIL bus_ack: got pe%0d data %h, want pe%0d data %h",
                              p, dout[p*32 +: 32], e.pe, e.data);
                  end
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input int p, input logic [3:0] off, input logic [31:0] d);
      addr[p*32 +: 32] = {26'd0, off, 2'b00};
      din[p*32 +: 32]  = d;
      wren[p]          = 1'b1;
      exp_q.push_back('{p, 1'b0, 32'd0});
      tick(1);
      wren = '0;
   endtask

   task automatic rd(input int p, input logic [3:0] off, input logic [31:0] expv);
      addr[p*32 +: 32] = {26'd0, off, 2'b00};
      rden[p]          = 1'b1;
      exp_q.push_back('{p, 1'b1, expv});
      tick(1);
      rden = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      gpio  = 16'hFFFF;
      wren  = '0;
      rden  = '0;
      addr  = '0;
      din   = '0;
      #23;
      n_vec++;
      if ({o_gpio, o_gpio_en} !== 32'd0) begin
         n_err++; $display("FAIL rst_gpio got %h want 0", {o_gpio, o_gpio_en});
      end
      n_vec++;
      if (dout !== 96'd0) begin n_err++; $display("FAIL rst_dout got %h want 0", dout); end
      n_vec++;
      if (valid !== 3'b000) begin n_err++; $display("FAIL rst_valid got %b want 000", valid); end
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL rst_irq got %b want 000", irq); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(4);
      wr(0, R_IRQ_EN, 32'hFFFF);
      wr(0, R_RISE, 32'hFFFF);
      wr(0, R_FALL, 32'hFFFF);
      wr(0, R_ROUTE, 32'h7);
      rd(1, R_STATUS, 32'h0);
      wr(2, R_EN, 32'h1);
      tick(5);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL en_no_spurious irq got %b want 000", irq); end
      rd(0, R_STATUS, 32'h0);
      rd(0, R_EN, 32'h1);
      rd(1, R_ROUTE, 32'h7);
      rd(2, R_IN, 32'hFFFF);
      wr(0, R_EN, 32'h0);
      gpio = 16'h0000;
      tick(6);
      wr(0, R_RISE, 32'h0);
      wr(0, R_FALL, 32'h0);
      wr(0, R_IRQ_EN, 32'h0);
      wr(0, R_ROUTE, 32'h0);
   endtask

   task automatic test_edge_latency();
      wr(0, R_RISE, 32'h0008);
      wr(0, R_IRQ_EN, 32'h0008);
      wr(0, R_ROUTE, 32'h2);
      wr(0, R_EN, 32'h1);
      wr(0, R_STATUS, 32'hFFFF);
      tick(2);
      gpio[3] = 1'b1;
      tick(LAT);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL lat_early irq got %b want 000", irq); end
      rd(1, R_STATUS, 32'h0);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL lat_mid irq got %b want 000", irq); end
      rd(1, R_STATUS, 32'h0008);
      n_vec++;
      if (irq !== 3'b010) begin n_err++; $display("FAIL lat_irq got %b want 010", irq); end
      wr(0, R_STATUS, 32'h0008);
      n_vec++;
      if (irq !== 3'b010) begin n_err++; $display("FAIL w1c_hold irq got %b want 010", irq); end
      tick(1);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL w1c_clear irq got %b want 000", irq); end
      gpio[3] = 1'b0;
      tick(8);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL fall_masked irq got %b want 000", irq); end
      rd(2, R_STATUS, 32'h0);
   endtask

   task automatic test_both_edges();
      wr(0, R_RISE, 32'h0001);
      wr(0, R_FALL, 32'h0001);
      wr(0, R_IRQ_EN, 32'h0001);
      wr(0, R_ROUTE, 32'h1);
      gpio[0] = 1'b1;
      tick(LAT + 3);
      n_vec++;
      if (irq !== 3'b001) begin n_err++; $display("FAIL both_rise irq got %b want 001", irq); end
      rd(0, R_STATUS, 32'h0001);
      wr(0, R_STATUS, 32'h0001);
      tick(2);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL both_clr irq got %b want 000", irq); end
      gpio[0] = 1'b0;
      tick(LAT + 3);
      n_vec++;
      if (irq !== 3'b001) begin n_err++; $display("FAIL both_fall irq got %b want 001", irq); end
      rd(0, R_STATUS, 32'h0001);
      wr(0, R_STATUS, 32'h0001);
      tick(2);
      gpio[0] = 1'b1;
      tick(LAT);
      wr(0, R_STATUS, 32'h0001);
      tick(2);
      n_vec++;
      if (irq !== 3'b001) begin n_err++; $display("FAIL set_beats_clr irq got %b want 001", irq); end
      rd(0, R_STATUS, 32'h0001);
      wr(0, R_EN, 32'h0);
      gpio = 16'h0000;
      tick(6);
      rd(1, R_STATUS, 32'h0);
   endtask

   task automatic test_out_ops();
      wr(0, R_OUT, 32'h00F0);
      n_vec++;
      if (o_gpio !== 16'h00F0) begin n_err++; $display("FAIL out_wr got %h want 00f0", o_gpio); end
      wr(1, R_SET, 32'h000F);
      n_vec++;
      if (o_gpio !== 16'h00FF) begin n_err++; $display("FAIL out_set got %h want 00ff", o_gpio); end
      wr(2, R_CLR, 32'h0030);
      n_vec++;
      if (o_gpio !== 16'h00CF) begin n_err++; $display("FAIL out_clr got %h want 00cf", o_gpio); end
      wr(0, R_TGL, 32'hFF00);
      n_vec++;
      if (o_gpio !== 16'hFFCF) begin n_err++; $display("FAIL out_tgl got %h want ffcf", o_gpio); end
      rd(0, R_OUT, 32'hFFCF);
      rd(1, R_SET, 32'h0);
      rd(2, R_TGL, 32'h0);
      n_vec++;
      if (o_gpio_en !== 16'h0000) begin n_err++; $display("FAIL dir_rst got %h want 0000", o_gpio_en); end
      wr(1, R_DIR, 32'hFFFF);
      n_vec++;
      if (o_gpio_en !== 16'hFFFF) begin n_err++; $display("FAIL dir_set got %h want ffff", o_gpio_en); end
      gpio = 16'hA5C3;
      tick(LAT + 2);
      rd(0, R_IN, 32'hA5C3);
      rd(2, R_DIR, 32'hFFFF);
   endtask

   task automatic test_back_to_back();
      addr[0 +: 32]  = {26'd0, R_OUT, 2'b00};
      din[0 +: 32]   = 32'h1111;
      addr[64 +: 32] = {26'd0, R_OUT, 2'b00};
      din[64 +: 32]  = 32'h2222;
      wren = 3'b101;
      exp_q.push_back('{0, 1'b0, 32'd0});
      exp_q.push_back('{2, 1'b0, 32'd0});
      tick(1);
      wren = '0;
      n_vec++;
      if (valid !== 3'b101) begin n_err++; $display("FAIL arb_valid got %b want 101", valid); end
      n_vec++;
      if (o_gpio !== 16'h1111) begin n_err++; $display("FAIL arb_out got %h want 1111", o_gpio); end
      // Read of OUT in the same cycle as a write returns the old value.
      addr[0 +: 32]  = {26'd0, R_DIR, 2'b00};
      din[0 +: 32]   = 32'h0;
      addr[32 +: 32] = {26'd0, R_OUT, 2'b00};
      din[32 +: 32]  = 32'h0;
      addr[64 +: 32] = {26'd0, R_OUT, 2'b00};
      wren = 3'b011;
      rden = 3'b100;
      exp_q.push_back('{0, 1'b0, 32'd0});
      exp_q.push_back('{1, 1'b0, 32'd0});
      exp_q.push_back('{2, 1'b1, 32'h1111});
      tick(1);
      wren = '0;
      rden = '0;
      n_vec++;
      if (o_gpio_en !== 16'h0000) begin n_err++; $display("FAIL arb_dir got %h want 0000", o_gpio_en); end
      n_vec++;
      if (o_gpio !== 16'h1111) begin n_err++; $display("FAIL arb_drop got %h want 1111", o_gpio); end
      wr(1, R_RSVD, 32'hFFFF_FFFF);
      rd(1, R_RSVD, 32'h0);
      rd(1, R_OUT, 32'h1111);
      rd(1, R_EN, 32'h0);
   endtask

   task automatic test_db_limit();
      wr(0, R_DB, 32'h10);
`ifdef GPIO_DEBOUNCE_EN
      rd(0, R_DB, 32'h10);
      wr(0, R_DB, 32'h4);
      wr(0, R_RISE, 32'h0008);
      wr(0, R_FALL, 32'h0);
      wr(0, R_IRQ_EN, 32'h0008);
      wr(0, R_ROUTE, 32'h2);
      wr(0, R_EN, 32'h1);
      wr(0, R_STATUS, 32'hFFFF);
      gpio[3] = 1'b1;
      tick(3);
      gpio[3] = 1'b0;
      tick(10);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL db_glitch irq got %b want 000", irq); end
      rd(1, R_STATUS, 32'h0);
      gpio[3] = 1'b1;
      tick(10);
      n_vec++;
      if (irq !== 3'b010) begin n_err++; $display("FAIL db_hold irq got %b want 010", irq); end
      rd(1, R_STATUS, 32'h0008);
      wr(0, R_STATUS, 32'h0008);
      tick(1);
      n_vec++;
      if (irq !== 3'b000) begin n_err++; $display("FAIL db_w1c irq got %b want 000", irq); end
`else
      rd(0, R_DB, 32'h0);
`endif
   endtask

   initial begin
      test_reset();
      test_edge_latency();
      test_both_edges();
      test_out_ops();
      test_back_to_back();
      test_db_limit();
      tick(3);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ack_missing got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
